decode_stage: RTL and testbench

- Instruction decode and register-read stage directly upstream of the integer ALU.
- Accepts a 32-bit RV32I instruction, reads rs1/rs2 from an internal 32x32 register file, and forms the ALU operands.
- Re-encodes OP-IMM instructions into the R-type {opcode, funct3, funct7} form the ALU decodes.
- Presents everything through a registered ID/EX boundary with a valid/ready handshake; writeback returns through a dedicated write port.

---
 rtl/rv_pkg.sv | 34 +++
 rtl/regfile_2r1w.sv | 39 +++
 rtl/decode_stage.sv | 151 +++++++++++++++
 tb/tb_decode_stage.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I decode constants and the ID/EX bundle.
// Imported by the decode stage and its register file.
package rv_pkg;

  localparam int DW = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SRL = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef struct packed {
    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic [6:0]    funct7;
    logic [DW-1:0] data1;
    logic [DW-1:0] data2;
    logic [4:0]    rd;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic          use_rs2;
    logic          reg_write;
    logic          illegal;
  } id_ex_t;

endpackage

// File: rtl/regfile_2r1w.sv
// 2-read 1-write register file, x0 hardwired to zero.
// Reads are combinational; the write lands at the clock edge.
module regfile_2r1w #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] mem_q [NREGS];
  logic [XLEN-1:0] mem_d [NREGS];

  always_comb begin
    mem_d = mem_q;
    if (we && wa != '0) mem_d[wa] = wd;
    mem_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : mem_q[ra1];
  assign rd2 = (ra2 == '0) ? '0 : mem_q[ra2];

endmodule

// File: rtl/decode_stage.sv
// RV32I decode/register-read stage feeding the integer ALU.
// OP-IMM is re-encoded as OP so the ALU sees one format.
module decode_stage
  import rv_pkg::*;
#(
  parameter int XLEN  = DW,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  input  logic [31:0]     instr_in,
  output logic            instr_ready,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] data1_out,
  output logic [XLEN-1:0] data2_out,
  output logic [4:0]      rd_out,
  output logic            reg_write_out,
  output logic            illegal_out
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rs1, rs2, rd;
  assign opc = instr_in[6:0];
  assign rd  = instr_in[11:7];
  assign f3  = instr_in[14:12];
  assign rs1 = instr_in[19:15];
  assign rs2 = instr_in[24:20];
  assign f7  = instr_in[31:25];

  logic [XLEN-1:0] rf_rd1, rf_rd2;

  regfile_2r1w #(
    .XLEN (XLEN),
    .NREGS(NREGS),
    .AW   (5)
  ) u_rf (
    .clk  (clk),
    .rst_n(rst_n),
    .ra1  (rs1),
    .ra2  (rs2),
    .rd1  (rf_rd1),
    .rd2  (rf_rd2),
    .we   (wb_en),
    .wa   (wb_addr),
    .wd   (wb_data)
  );

  logic wb_live;
  assign wb_live = wb_en && (wb_addr != '0);

  logic [XLEN-1:0] rs1_val, rs2_val;
  assign rs1_val = (wb_live && wb_addr == rs1) ? wb_data : rf_rd1;
  assign rs2_val = (wb_live && wb_addr == rs2) ? wb_data : rf_rd2;

  logic op_ok, imm_alu, imm_sh;
  assign op_ok = (f7 == F7_BASE && f3 != 3'b010 && f3 != 3'b011)
              || (f7 == F7_SUB && f3 == F3_ADD);
  assign imm_alu = (f3 == F3_ADD) || (f3 == F3_XOR)
                || (f3 == F3_OR)  || (f3 == F3_AND);
  assign imm_sh = (f3 == F3_SLL || f3 == F3_SRL) && f7 == F7_BASE;

  id_ex_t dec;

  always_comb begin
    dec         = '0;
    dec.opcode  = opc;
    dec.funct3  = f3;
    dec.funct7  = f7;
    dec.rd      = rd;
    dec.rs1     = rs1;
    dec.rs2     = rs2;
    dec.data1   = rs1_val;
    dec.data2   = rs2_val;
    dec.use_rs2 = 1'b1;
    dec.illegal = 1'b1;
    unique case (1'b1)
      opc == OPC_OP: begin
        if (op_ok) dec.illegal = 1'b0;
      end
      opc == OPC_OP_IMM: begin
        if (imm_alu || imm_sh) begin
          dec.illegal = 1'b0;
          dec.opcode  = OPC_OP;
          dec.funct7  = F7_BASE;
          dec.use_rs2 = 1'b0;
          dec.data2   = imm_sh
            ? {{(XLEN-5){1'b0}}, rs2}
            : {{(XLEN-12){instr_in[31]}}, instr_in[31:20]};
        end
      end
      default: ;
    endcase
    dec.reg_write = !dec.illegal && (rd != '0);
  end

  logic   ex_valid_q, ex_valid_d;
  id_ex_t ex_q, ex_d;
  logic   accept;

  assign instr_ready = !ex_valid_q || ex_ready;
  assign accept      = instr_valid && instr_ready;

  // A stalled bundle keeps tracking writebacks to its source registers
  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_d       = ex_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (accept) begin
      ex_valid_d = 1'b1;
      ex_d       = dec;
    end else if (ex_ready) begin
      ex_valid_d = 1'b0;
    end else if (ex_valid_q && wb_live) begin
      if (wb_addr == ex_q.rs1) ex_d.data1 = wb_data;
      if (ex_q.use_rs2 && wb_addr == ex_q.rs2) ex_d.data2 = wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ex_q       <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_q       <= ex_d;
    end
  end

  assign ex_valid      = ex_valid_q;
  assign opcode        = ex_q.opcode;
  assign funct3        = ex_q.funct3;
  assign funct7        = ex_q.funct7;
  assign data1_out     = ex_q.data1;
  assign data2_out     = ex_q.data2;
  assign rd_out        = ex_q.rd;
  assign reg_write_out = ex_q.reg_write;
  assign illegal_out   = ex_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed instructions,
// expected bundles queued at issue, checked when consumed.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] instr_in;
  logic        instr_ready;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ex_valid;
  logic        ex_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] data1_out;
  logic [31:0] data2_out;
  logic [4:0]  rd_out;
  logic        reg_write_out;
  logic        illegal_out;

  decode_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .instr_in     (instr_in),
    .instr_ready  (instr_ready),
    .flush        (flush),
    .wb_en        (wb_en),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .opcode       (opcode),
    .funct3       (funct3),
    .funct7       (funct7),
    .data1_out    (data1_out),
    .data2_out    (data2_out),
    .rd_out       (rd_out),
    .reg_write_out(reg_write_out),
    .illegal_out  (illegal_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [4:0]  rd;
    logic        rw;
    logic        ill;
    logic        dc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic exp_t mk(
    input logic [6:0] opc, input logic [2:0] f3,
    input logic [6:0] f7, input logic [31:0] d1,
    input logic [31:0] d2, input logic [4:0] rd,
    input logic rw, input logic ill);
    exp_t e;
    e.opc = opc; e.f3 = f3; e.f7 = f7;
    e.d1 = d1; e.d2 = d2; e.rd = rd;
    e.rw = rw; e.ill = ill; e.dc = ill;
    return e;
  endfunction

  // monitor: compare each bundle the ALU consumes
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && ex_valid && ex_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 32'(ex_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("opcode", 32'(opcode), 32'(e.opc));
          chk("funct3", 32'(funct3), 32'(e.f3));
          chk("funct7", 32'(funct7), 32'(e.f7));
          chk("rd_out", 32'(rd_out), 32'(e.rd));
          chk("reg_write", 32'(reg_write_out), 32'(e.rw));
          chk("illegal", 32'(illegal_out), 32'(e.ill));
          if (!e.dc) begin
            chk("data1", data1_out, e.d1);
            chk("data2", data2_out, e.d2);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    step();
    wb_en = 1'b0;
  endtask

  task automatic send(input logic [31:0] ins, input exp_t e);
    chk("instr_ready_at_send", 32'(instr_ready), 32'd1);
    instr_valid = 1'b1;
    instr_in    = ins;
    sb.push_back(e);
    step();
    instr_valid = 1'b0;
    wb_en       = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      step();
      n++;
    end
    chk("drain_left", 32'(sb.size()), 32'd0);
  endtask

  localparam logic [31:0] ADD_7_5_6  = 32'h006283B3;
  localparam logic [31:0] ADDI_1_5_M = 32'hFFF28093;
  localparam logic [31:0] SLLI_1_5_4 = 32'h00429093;
  localparam logic [31:0] SUB_3_5_6  = 32'h406281B3;
  localparam logic [31:0] SRAI       = 32'h4012D093;
  localparam logic [31:0] LUI        = 32'h123450B7;
  localparam logic [31:0] SLT_7_5_6  = 32'h0062A3B3;
  localparam logic [31:0] ADD_2_0_0  = 32'h00000133;
  localparam logic [31:0] ADD_0_5_6  = 32'h00628033;

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr_in = '0;
    flush = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    ex_ready = 1'b1;
    #12;
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_instr_ready", 32'(instr_ready), 32'd1);
    chk("rst_opcode", 32'(opcode), 32'd0);
    chk("rst_funct3", 32'(funct3), 32'd0);
    chk("rst_funct7", 32'(funct7), 32'd0);
    chk("rst_data1", data1_out, 32'd0);
    chk("rst_data2", data2_out, 32'd0);
    chk("rst_rd", 32'(rd_out), 32'd0);
    chk("rst_reg_write", 32'(reg_write_out), 32'd0);
    chk("rst_illegal", 32'(illegal_out), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    send(ADD_7_5_6, mk(7'h33, 3'd0, 7'h00, 32'h0, 32'h0, 5'd7, 1'b1, 1'b0));
    wr(5'd5, 32'h10);
    wr(5'd6, 32'h3);
    send(ADD_7_5_6, mk(7'h33, 3'd0, 7'h00, 32'h10, 32'h3, 5'd7, 1'b1, 1'b0));
    send(ADDI_1_5_M,
         mk(7'h33, 3'd0, 7'h00, 32'h10, 32'hFFFFFFFF, 5'd1, 1'b1, 1'b0));
    send(SLLI_1_5_4, mk(7'h33, 3'd1, 7'h00, 32'h10, 32'h4, 5'd1, 1'b1, 1'b0));
    send(SUB_3_5_6, mk(7'h33, 3'd0, 7'h20, 32'h10, 32'h3, 5'd3, 1'b1, 1'b0));

    // flush beats a same-cycle accept
    instr_valid = 1'b1; instr_in = ADD_7_5_6; flush = 1'b1;
    step();
    instr_valid = 1'b0; flush = 1'b0;
    chk("flush_ex_valid", 32'(ex_valid), 32'd0);
    drain();

    // same-cycle bypass, then stall with writeback into held rs2
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hAA;
    send(ADD_7_5_6, mk(7'h33, 3'd0, 7'h00, 32'hAA, 32'h55, 5'd7, 1'b1, 1'b0));
    ex_ready = 1'b0;
    wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'h55;
    step();
    wb_en = 1'b0;
    chk("stall_data2_bypass", data2_out, 32'h55);
    chk("stall_data1", data1_out, 32'hAA);
    chk("stall_instr_ready", 32'(instr_ready), 32'd0);
    chk("stall_ex_valid", 32'(ex_valid), 32'd1);
    step();
    chk("stall_hold_data2", data2_out, 32'h55);
    chk("stall_hold_rd", 32'(rd_out), 32'd7);
    ex_ready = 1'b1;
    step();

    // immediate operand must ignore a write to its rs2 field (x31)
    send(ADDI_1_5_M,
         mk(7'h33, 3'd0, 7'h00, 32'hAA, 32'hFFFFFFFF, 5'd1, 1'b1, 1'b0));
    ex_ready = 1'b0;
    wr(5'd31, 32'h1234);
    chk("stall_imm_kept", data2_out, 32'hFFFFFFFF);
    ex_ready = 1'b1;
    step();

    send(SRAI, mk(7'h13, 3'd5, 7'h20, 32'h0, 32'h0, 5'd1, 1'b0, 1'b1));
    send(LUI, mk(7'h37, 3'd5, 7'h09, 32'h0, 32'h0, 5'd1, 1'b0, 1'b1));
    send(SLT_7_5_6, mk(7'h33, 3'd2, 7'h00, 32'h0, 32'h0, 5'd7, 1'b0, 1'b1));

    // x0 writes never land nor bypass
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEAD;
    send(ADD_2_0_0, mk(7'h33, 3'd0, 7'h00, 32'h0, 32'h0, 5'd2, 1'b1, 1'b0));
    send(ADD_2_0_0, mk(7'h33, 3'd0, 7'h00, 32'h0, 32'h0, 5'd2, 1'b1, 1'b0));
    send(ADD_0_5_6, mk(7'h33, 3'd0, 7'h00, 32'hAA, 32'h55, 5'd0, 1'b0, 1'b0));
    drain();

    // async reset while stalled
    send(ADD_7_5_6, mk(7'h33, 3'd0, 7'h00, 32'hAA, 32'h55, 5'd7, 1'b1, 1'b0));
    ex_ready = 1'b0;
    step();
    chk("pre_arst_ex_valid", 32'(ex_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ex_valid", 32'(ex_valid), 32'd0);
    chk("arst_data1", data1_out, 32'd0);
    chk("arst_reg_write", 32'(reg_write_out), 32'd0);
    chk("arst_instr_ready", 32'(instr_ready), 32'd1);
    sb.delete();
    #3;
    rst_n = 1'b1;
    ex_ready = 1'b1;
    step();
    send(ADD_7_5_6, mk(7'h33, 3'd0, 7'h00, 32'h0, 32'h0, 5'd7, 1'b1, 1'b0));
    drain();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
